// File: rtl/dt_pack.sv
// Packs a 128x128 8-bit result map into 1024 16-bit binary words (pixel = res_di > thr).
// Every output is registered. Each word takes 16 READ cycles and then one WRITE cycle.
module dt_pack #(
    parameter int unsigned THR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [THR_W-1:0] thr_i,
    output logic             res_rd_o,
    output logic [13:0]      res_addr_o,
    input  logic [THR_W-1:0] res_di_i,
    output logic             sti_wr_o,
    output logic [9:0]       sti_addr_o,
    output logic [15:0]      sti_do_o,
    output logic [14:0]      obj_cnt_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StFinish} state_e;

    state_e           state_q, state_d;
    logic [THR_W-1:0] thr_q, thr_d;
    // Holds the first 15 bits of a word; the col-15 bit is merged straight into sti_do.
    logic [14:0]      sh_q, sh_d;
    logic             res_rd_q, res_rd_d;
    logic [13:0]      res_addr_q, res_addr_d;
    logic             sti_wr_q, sti_wr_d;
    logic [9:0]       sti_addr_q, sti_addr_d;
    logic [15:0]      sti_do_q, sti_do_d;
    logic [14:0]      obj_cnt_q, obj_cnt_d;
    logic             done_q, done_d;

    logic pix_bit;
    logic last_col;

    assign pix_bit  = (res_di_i > thr_q);
    assign last_col = (res_addr_q[3:0] == 4'hF);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            thr_q      <= '0;
            sh_q       <= '0;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            sti_wr_q   <= 1'b0;
            sti_addr_q <= '0;
            sti_do_q   <= '0;
            obj_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            sh_q       <= sh_d;
            res_rd_q   <= res_rd_d;
            res_addr_q <= res_addr_d;
            sti_wr_q   <= sti_wr_d;
            sti_addr_q <= sti_addr_d;
            sti_do_q   <= sti_do_d;
            obj_cnt_q  <= obj_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StRead;
            StRead:   if (last_col) state_d = StWrite;
            StWrite:  state_d = (sti_addr_q == 10'h3FF) ? StFinish : StRead;
            StFinish: state_d = StFinish;
        endcase
    end

    always_comb begin
        thr_d      = thr_q;
        sh_d       = sh_q;
        res_rd_d   = res_rd_q;
        res_addr_d = res_addr_q;
        sti_wr_d   = sti_wr_q;
        sti_addr_d = sti_addr_q;
        sti_do_d   = sti_do_q;
        obj_cnt_d  = obj_cnt_q;
        done_d     = done_q;
        unique case (state_q)
            StIdle: begin
                thr_d      = thr_i;
                res_rd_d   = 1'b1;
                res_addr_d = '0;
            end
            StRead: begin
                sh_d = {sh_q[13:0], pix_bit};
                if (pix_bit) obj_cnt_d = obj_cnt_q + 15'd1;
                if (!last_col) begin
                    res_addr_d = res_addr_q + 14'd1;
                end else begin
                    sti_wr_d   = 1'b1;
                    sti_addr_d = res_addr_q[13:4];
                    sti_do_d   = {sh_q, pix_bit};
                    res_rd_d   = 1'b0;
                end
            end
            StWrite: begin
                sti_wr_d = 1'b0;
                if (sti_addr_q != 10'h3FF) begin
                    res_rd_d   = 1'b1;
                    res_addr_d = res_addr_q + 14'd1;
                end else begin
                    done_d = 1'b1;
                end
            end
            StFinish: begin
                done_d   = 1'b1;
                res_rd_d = 1'b0;
                sti_wr_d = 1'b0;
            end
        endcase
    end

    assign res_rd_o   = res_rd_q;
    assign res_addr_o = res_addr_q;
    assign sti_wr_o   = sti_wr_q;
    assign sti_addr_o = sti_addr_q;
    assign sti_do_o   = sti_do_q;
    assign obj_cnt_o  = obj_cnt_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_dt_pack.sv
// Scoreboard bench for dt_pack: expected words are queued by the stimulus,
// and a negedge monitor pops and compares them on every sti_wr pulse.
module tb_dt_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  thr;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        sti_wr;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;
    logic [14:0] obj_cnt;
    logic        done;

    logic [7:0] res_mem [16384];

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   edges;
    logic [13:0] prev_addr = '0;
    logic        prev_rst  = 1'b0;

    always #5 clk = ~clk;

    assign res_di = res_mem[res_addr];

    dt_pack #(.THR_W(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .thr_i      (thr),
        .res_rd_o   (res_rd),
        .res_addr_o (res_addr),
        .res_di_i   (res_di),
        .sti_wr_o   (sti_wr),
        .sti_addr_o (sti_addr),
        .sti_do_o   (sti_do),
        .obj_cnt_o  (obj_cnt),
        .done_o     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && sti_wr === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%h, none expected", sti_addr, sti_do);
            end else begin
                mon_e = sb.pop_front();
                check("sti_addr", 32'(sti_addr), 32'(mon_e.addr));
                check("sti_do", 32'(sti_do), 32'(mon_e.data));
            end
        end
        if (sti_wr === 1'b1 && res_rd === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wr_rd_overlap: sti_wr=1 res_rd=1 at addr %0d", res_addr);
        end
        if (rst_n === 1'b1 && prev_rst && res_addr < prev_addr) begin
            checks++;
            errors++;
            $display("FAIL res_addr_wrap: got %0d after %0d", res_addr, prev_addr);
        end
        prev_addr <= res_addr;
        prev_rst  <= rst_n;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 16384; i++) res_mem[i] = v;
    endtask

    task automatic push_words(input int first, input int n, input logic [15:0] d);
        exp_t x;
        for (int i = first; i < first + n; i++) begin
            x.addr = 10'(i);
            x.data = d;
            sb.push_back(x);
        end
    endtask

    task automatic reset_dut();
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        sb.delete();
    endtask

    task automatic release_rst(input logic [7:0] t);
        thr   = t;
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_res_rd"}, 32'(res_rd), 0);
        check({tag, "_sti_wr"}, 32'(sti_wr), 0);
        check({tag, "_res_addr"}, 32'(res_addr), 0);
        check({tag, "_sti_addr"}, 32'(sti_addr), 0);
        check({tag, "_sti_do"}, 32'(sti_do), 0);
        check({tag, "_obj_cnt"}, 32'(obj_cnt), 0);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_pending_words"}, 32'(sb.size()), 0);
    endtask

    // Counts edges from release (first edge = 0) until done is seen.
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        edges = -1;
        while (edges < 17500 && !seen) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 0) begin
                check({name, "_idle_res_rd"}, 32'(res_rd), 1);
                check({name, "_idle_res_addr"}, 32'(res_addr), 0);
            end
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_edge"}, 32'(edges), 17408);
    endtask

    initial begin
        rst_n = 1'b0;
        thr   = 8'd0;
        fill_mem(8'd0);
        repeat (3) tick();
        @(posedge clk);
        #1;
        check_zero("reset");

        // Single object pixel at col 0.
        reset_dut();
        res_mem[0] = 8'd1;
        push_words(0, 1, 16'h8000);
        push_words(1, 1, 16'h0000);
        release_rst(8'd0);
        wait_drain("px0", 60);
        check("px0_obj_cnt", 32'(obj_cnt), 1);

        // Strict compare at col 15; thr changes after latching are ignored.
        reset_dut();
        fill_mem(8'd0);
        res_mem[15] = 8'd5;
        push_words(0, 1, 16'h0001);
        release_rst(8'd4);
        tick();
        thr = 8'd5;
        wait_drain("col15_thr4", 40);
        check("col15_thr4_obj_cnt", 32'(obj_cnt), 1);

        reset_dut();
        push_words(0, 1, 16'h0000);
        release_rst(8'd5);
        wait_drain("col15_thr5", 40);
        check("col15_thr5_obj_cnt", 32'(obj_cnt), 0);

        // Ramp in word 0, alternating 0/3 in word 1.
        reset_dut();
        fill_mem(8'd0);
        for (int c = 0; c < 16; c++) begin
            res_mem[c]      = 8'(c);
            res_mem[16 + c] = (c % 2 == 1) ? 8'd3 : 8'd0;
        end
        push_words(0, 1, 16'h7FFF);
        push_words(1, 1, 16'h5555);
        release_rst(8'd0);
        wait_drain("ramp_thr0", 60);
        check("ramp_thr0_obj_cnt", 32'(obj_cnt), 23);

        reset_dut();
        push_words(0, 1, 16'h00FF);
        push_words(1, 1, 16'h0000);
        release_rst(8'd7);
        wait_drain("ramp_thr7", 60);
        check("ramp_thr7_obj_cnt", 32'(obj_cnt), 8);

        // Full pass of saturated pixels.
        reset_dut();
        fill_mem(8'hFF);
        push_words(0, 1024, 16'hFFFF);
        release_rst(8'hFE);
        wait_done("full_ff");
        check("full_ff_obj_cnt", 32'(obj_cnt), 16384);
        check("full_ff_res_addr", 32'(res_addr), 16383);
        repeat (5) tick();
        check("full_ff_pending_words", 32'(sb.size()), 0);
        check("finish_done_hold", 32'(done), 1);
        check("finish_res_rd", 32'(res_rd), 0);
        check("finish_sti_addr", 32'(sti_addr), 1023);
        check("finish_sti_do", 32'(sti_do), 16'hFFFF);
        check("finish_obj_cnt", 32'(obj_cnt), 16384);

        // Abort during READ of word 10, then a complete restarted pass.
        reset_dut();
        fill_mem(8'd0);
        push_words(0, 10, 16'h0000);
        release_rst(8'd0);
        wait_drain("abort_pre", 10 * 17 + 40);
        repeat (3) tick();
        check("abort_in_read", 32'(res_rd), 1);
        check("abort_word", 32'(res_addr[13:4]), 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("abort");
        tick();
        sb.delete();
        push_words(0, 1024, 16'h0000);
        release_rst(8'd0);
        wait_done("restart");
        check("restart_obj_cnt", 32'(obj_cnt), 0);
        tick();
        check("restart_pending_words", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
